maxpool_2_2: RTL and testbench
==============================

// Module: maxpool_2_2
// PURPOSE
//  2x2 stride-2 max-pooling stage fed directly by gen_2_2. gen_2_2 emits a sliding
//  (stride-1) 2x2 window per ReLU pixel; this block keeps only the stride-2 windows
//  (even window-row, even window-col), reduces each to its max in a 2-stage pipeline
//  and streams pooled pixels to the next conv/FC stage with an end-of-map flag.
// PARAMETERS
//  DATA_W        22  width of one ReLU pixel (unsigned, post-ReLU >= 0)
//  reludata_num  6   input feature-map width in pixels (>= 2); window cols = reludata_num-1
//  relurow_num   6   input feature-map height in pixels (>= 2); window rows = relurow_num-1
// PORTS
//  clk            in   1         system clock, rising edge
//  rstn           in   1         asynchronous active-low reset
//  gen_2_2_valid  in   1         window valid strobe from gen_2_2 (single-cycle, no backpressure)
//  x_m_1          in   2*DATA_W  upper row of window: [2W-1:W]=left pixel, [W-1:0]=right pixel
//  x_m_2          in   2*DATA_W  lower row of window, same packing
//  pool_valid     out  1         pooled pixel valid (one cycle per pixel)
//  pool_data      out  DATA_W    max of the 4 window pixels
//  pool_last      out  1         high with pool_valid on the final pooled pixel of a map
// BEHAVIOUR
//  - Reset (rstn=0, async): pool_valid=0, pool_data=0, pool_last=0, col_cnt=0, row_cnt=0,
//    pipeline valid bits cleared; any in-flight window is discarded, next window counts as (0,0).
//  - Counters: col_cnt 0..reludata_num-2, row_cnt 0..relurow_num-2, advance only on
//    gen_2_2_valid. col wraps to 0 and row_cnt++ at col=reludata_num-2; row wraps to 0 at
//    row=relurow_num-2 and col wrap -> next window is (0,0) of the next map (back-to-back maps ok).
//  - Keep = gen_2_2_valid & ~col_cnt[0] & ~row_cnt[0]. Odd trailing col/row windows dropped
//    (floor): pooled size = (reludata_num/2) x (relurow_num/2).
//  - Stage 1 (reg): m_top = max(x_m_1 halves), m_bot = max(x_m_2 halves), v1 = keep,
//    last1 = keep & window is last kept window of map (col=2*(reludata_num/2)-2,
//    row=2*(relurow_num/2)-2).
//  - Stage 2 (reg): pool_data = max(m_top,m_bot), pool_valid = v1, pool_last = last1.
//  - Latency: pool_valid asserts exactly 2 clk after the accepted gen_2_2_valid cycle.
//  - Throughput: one window per cycle; consecutive valid windows fully pipelined.
//  - Comparison unsigned; ties pick either (equal values). No overflow possible.
//  - pool_data holds its last value while pool_valid=0 (stage regs load only when v=1);
//    pool_last is 0 whenever pool_valid=0.
//  - Gaps (gen_2_2_valid=0) do not advance counters or pipeline valid bits.
// STRUCTURE
//  - Shared include cnn_defs.vh: DATA_W (22), default map dimensions, packing indices
//    (upper/lower, left/right slice macros) common to gen_2_2 and this block.
//  - Sub-module max2 #(DATA_W): combinational unsigned max of two operands; instantiated
//    three times (top, bottom, final). Counters, keep logic and pipeline regs in top.
// TESTING
//  1 6x6 map, pixel(r,c)=r*6+c, windows driven by gen_2_2 at 1/4 rate -> 9 outputs,
//    values 7,9,11,19,21,23,31,33,35; pool_last only on 35; each 2 clk after its window.
//  2 Same map, gen_2_2_valid every cycle -> same 9 values, no gaps lost, latency 2.
//  3 reludata_num=5, relurow_num=5 (odd) -> 4 outputs (2x2); col/row 3 windows dropped.
//  4 Window x_m_1={0,0}, x_m_2={0,22'h3FFFFF} at (0,0) -> pool_data=22'h3FFFFF (unsigned max).
//  5 Two 6x6 maps back-to-back -> 18 outputs, pool_last on 9th and 18th only.
//  6 rstn pulsed low mid-map after 10 windows -> outputs 0 immediately, no spurious
//    pool_valid; fresh map after release yields the full 9-pixel sequence from (0,0).

Source files
------------

// File: rtl/maxpool_2_2_pkg.sv
// Shared constants for the 2x2 stride-2 max-pooling stage that follows gen_2_2.
// Pixel width and default map size match the producer; cnt_w sizes the window counters.
package maxpool_2_2_pkg;

    localparam int DEF_DATA_W = 22;
    localparam int DEF_MAP_W  = 6;
    localparam int DEF_MAP_H  = 6;

    // Bits needed to hold a window index 0..n-2 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n - 1) : 1;
    endfunction

endpackage

// File: rtl/maxpool_2_2_max2.sv
// Combinational unsigned maximum of two pixels; ties return either (they are equal).
module max2 #(
    parameter int DATA_W = 22
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    assign y = (a >= b) ? a : b;

endmodule

// File: rtl/maxpool_2_2.sv
// Keeps the even/even windows of gen_2_2's stride-1 stream and reduces each to its
// maximum over a two-register pipeline, flagging the final pooled pixel of each map.
module maxpool_2_2
    import maxpool_2_2_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int reludata_num = DEF_MAP_W,
    parameter int relurow_num  = DEF_MAP_H
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                gen_2_2_valid,
    input  logic [2*DATA_W-1:0] x_m_1,
    input  logic [2*DATA_W-1:0] x_m_2,
    output logic                pool_valid,
    output logic [DATA_W-1:0]   pool_data,
    output logic                pool_last
);

    localparam int CW = cnt_w(reludata_num);
    localparam int RW = cnt_w(relurow_num);

    localparam logic [CW-1:0] COL_END  = CW'(reludata_num - 2);
    localparam logic [RW-1:0] ROW_END  = RW'(relurow_num - 2);
    // Last window that survives the floor: odd trailing col/row windows never count.
    localparam logic [CW-1:0] COL_LAST = CW'(2 * (reludata_num / 2) - 2);
    localparam logic [RW-1:0] ROW_LAST = RW'(2 * (relurow_num / 2) - 2);

    logic [CW-1:0]     col_cnt;
    logic [RW-1:0]     row_cnt;
    logic              keep;
    logic              last_win;
    logic [DATA_W-1:0] top_max;
    logic [DATA_W-1:0] bot_max;
    logic [DATA_W-1:0] win_max;
    logic [DATA_W-1:0] m_top;
    logic [DATA_W-1:0] m_bot;
    logic              v1;
    logic              last1;

    // NOTE: every register below uses non-blocking assignment so all stages sample
    // the pre-edge values together; blocking here would collapse the pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (gen_2_2_valid) begin
            if (col_cnt == COL_END) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == ROW_END) ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    assign keep     = gen_2_2_valid & ~col_cnt[0] & ~row_cnt[0];
    assign last_win = (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);

    max2 #(.DATA_W(DATA_W)) u_max_top (
        .a (x_m_1[2*DATA_W-1:DATA_W]),
        .b (x_m_1[DATA_W-1:0]),
        .y (top_max)
    );

    max2 #(.DATA_W(DATA_W)) u_max_bot (
        .a (x_m_2[2*DATA_W-1:DATA_W]),
        .b (x_m_2[DATA_W-1:0]),
        .y (bot_max)
    );

    max2 #(.DATA_W(DATA_W)) u_max_fin (
        .a (m_top),
        .b (m_bot),
        .y (win_max)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            m_top <= '0;
            m_bot <= '0;
        end else begin
            v1    <= keep;
            last1 <= keep & last_win;
            if (keep) begin
                m_top <= top_max;
                m_bot <= bot_max;
            end
        end
    end

    // Data regs load only on a valid beat so pool_data holds between pixels.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pool_valid <= 1'b0;
            pool_last  <= 1'b0;
            pool_data  <= '0;
        end else begin
            pool_valid <= v1;
            pool_last  <= last1;
            if (v1) begin
                pool_data <= win_max;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2_2.sv
// Randomised bench for maxpool_2_2: a 6x6 and a 5x5 instance checked every cycle
// against a map-level reference model, plus literal expectations for known maps.
module tb_maxpool_2_2;

    localparam int DW = 22;

    typedef struct packed {
        logic [31:0]   due;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } cap_t;

    logic          clk;
    logic          rstn;
    logic          gv   [2];
    logic [2*DW-1:0] x1 [2];
    logic [2*DW-1:0] x2 [2];
    logic          vld  [2];
    logic [DW-1:0] dat  [2];
    logic          lst  [2];

    int   tests;
    int   fails;
    int   cyc;
    exp_t q0[$];
    exp_t q1[$];
    cap_t cap0[$];
    cap_t cap1[$];
    logic [DW-1:0] held [2];
    logic [DW-1:0] img [6][6];

    maxpool_2_2 #(.DATA_W(DW), .reludata_num(6), .relurow_num(6)) dut_a (
        .clk           (clk),
        .rstn          (rstn),
        .gen_2_2_valid (gv[0]),
        .x_m_1         (x1[0]),
        .x_m_2         (x2[0]),
        .pool_valid    (vld[0]),
        .pool_data     (dat[0]),
        .pool_last     (lst[0])
    );

    maxpool_2_2 #(.DATA_W(DW), .reludata_num(5), .relurow_num(5)) dut_b (
        .clk           (clk),
        .rstn          (rstn),
        .gen_2_2_valid (gv[1]),
        .x_m_1         (x1[1]),
        .x_m_2         (x2[1]),
        .pool_valid    (vld[1]),
        .pool_data     (dat[1]),
        .pool_last     (lst[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Compare process: every cycle, each DUT must either show the next due pixel or be idle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                check("reset_valid", 64'(vld[d]), 64'd0);
                check("reset_data", 64'(dat[d]), 64'd0);
                check("reset_last", 64'(lst[d]), 64'd0);
                held[d] = '0;
            end else begin
                exp_t e;
                bit   have;
                have = 1'b0;
                if (d == 0 && q0.size() > 0 && q0[0].due == 32'(cyc)) begin
                    e = q0.pop_front();
                    have = 1'b1;
                end
                if (d == 1 && q1.size() > 0 && q1[0].due == 32'(cyc)) begin
                    e = q1.pop_front();
                    have = 1'b1;
                end
                if (have) begin
                    check("pix_valid", 64'(vld[d]), 64'd1);
                    check("pix_data", 64'(dat[d]), 64'(e.data));
                    check("pix_last", 64'(lst[d]), 64'(e.last));
                    held[d] = e.data;
                end else begin
                    check("idle_valid", 64'(vld[d]), 64'd0);
                    check("idle_last", 64'(lst[d]), 64'd0);
                    check("idle_hold", 64'(dat[d]), 64'(held[d]));
                end
                if (vld[d]) begin
                    if (d == 0) cap0.push_back('{dat[d], lst[d]});
                    else        cap1.push_back('{dat[d], lst[d]});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Streams the sliding windows of img (h x w) into DUT d; stops after limit windows if limit >= 0.
    task automatic send_map(input int d, input int h, input int w,
                            input int gmin, input int gmax, input int limit);
        int n;
        n = 0;
        for (int r = 0; r < h - 1; r++) begin
            for (int c = 0; c < w - 1; c++) begin
                if (limit >= 0 && n == limit) return;
                gv[d] = 1'b1;
                x1[d] = {img[r][c], img[r][c+1]};
                x2[d] = {img[r+1][c], img[r+1][c+1]};
                if (r % 2 == 0 && c % 2 == 0) begin
                    exp_t e;
                    e.due  = 32'(cyc + 2);
                    e.data = mx(mx(img[r][c], img[r][c+1]), mx(img[r+1][c], img[r+1][c+1]));
                    e.last = (r == 2 * (h / 2) - 2) && (c == 2 * (w / 2) - 2);
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
                n++;
                @(posedge clk);
                #1;
                gv[d] = 1'b0;
                x1[d] = $urandom();
                x2[d] = $urandom();
                idle($urandom_range(gmax, gmin));
            end
        end
    endtask

    task automatic fill_ramp(input int w);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                img[r][c] = DW'(r * w + c);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                img[r][c] = DW'($urandom());
    endtask

    task automatic check_ramp6(input int base);
        int lit [9];
        lit = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
        for (int i = 0; i < 9; i++) begin
            check("ramp6_value", 64'(cap0[base+i].data), 64'(lit[i]));
            check("ramp6_last", 64'(cap0[base+i].last), 64'(i == 8));
        end
    endtask

    task automatic do_reset(input int hold);
        rstn = 1'b0;
        q0.delete();
        q1.delete();
        idle(hold);
        rstn = 1'b1;
    endtask

    initial begin
        int lit5 [4];
        int nlast;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rstn  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            gv[d] = 1'b0;
            x1[d] = '0;
            x2[d] = '0;
            held[d] = '0;
        end
        idle(3);
        rstn = 1'b1;
        idle(1);

        // 6x6 ramp at quarter rate.
        fill_ramp(6);
        cap0.delete();
        send_map(0, 6, 6, 3, 3, -1);
        idle(4);
        check("ramp6_count", 64'(cap0.size()), 64'd9);
        if (cap0.size() == 9) check_ramp6(0);

        // Same map, back-to-back windows.
        cap0.delete();
        send_map(0, 6, 6, 0, 0, -1);
        idle(4);
        check("ramp6_b2b_count", 64'(cap0.size()), 64'd9);
        if (cap0.size() == 9) check_ramp6(0);

        // Odd 5x5 map on the second instance.
        fill_ramp(5);
        cap1.delete();
        send_map(1, 5, 5, 0, 1, -1);
        idle(4);
        lit5 = '{6, 8, 16, 18};
        check("odd_count", 64'(cap1.size()), 64'd4);
        if (cap1.size() == 4)
            for (int i = 0; i < 4; i++) begin
                check("odd_value", 64'(cap1[i].data), 64'(lit5[i]));
                check("odd_last", 64'(cap1[i].last), 64'(i == 3));
            end

        // Unsigned max: an all-ones pixel must win over zeros.
        fill_rand();
        img[0][0] = '0;
        img[0][1] = '0;
        img[1][0] = '0;
        img[1][1] = 22'h3FFFFF;
        cap0.delete();
        send_map(0, 6, 6, 0, 2, -1);
        idle(4);
        check("umax_count", 64'(cap0.size()), 64'd9);
        if (cap0.size() > 0) check("umax_value", 64'(cap0[0].data), 64'h3FFFFF);

        // Two maps back-to-back: pool_last on 9th and 18th only.
        fill_ramp(6);
        cap0.delete();
        send_map(0, 6, 6, 0, 0, -1);
        send_map(0, 6, 6, 0, 0, -1);
        idle(4);
        check("b2b_count", 64'(cap0.size()), 64'd18);
        if (cap0.size() == 18) begin
            check_ramp6(0);
            check_ramp6(9);
        end
        nlast = 0;
        foreach (cap0[i]) nlast += int'(cap0[i].last);
        check("b2b_last_count", 64'(nlast), 64'd2);

        // Reset mid-map after 10 windows, then after 5 (kept window still in flight).
        send_map(0, 6, 6, 0, 0, 10);
        do_reset(3);
        cap0.delete();
        send_map(0, 6, 6, 0, 0, -1);
        idle(4);
        check("rst10_count", 64'(cap0.size()), 64'd9);
        if (cap0.size() == 9) check_ramp6(0);

        send_map(0, 6, 6, 0, 0, 5);
        do_reset(2);
        cap0.delete();
        send_map(0, 6, 6, 1, 2, -1);
        idle(4);
        check("rst5_count", 64'(cap0.size()), 64'd9);
        if (cap0.size() == 9) check_ramp6(0);

        // Random maps on both instances.
        for (int k = 0; k < 6; k++) begin
            fill_rand();
            send_map(k % 2, (k % 2) ? 5 : 6, (k % 2) ? 5 : 6, 0, 2, -1);
        end
        idle(4);
        check("drain_q0", 64'(q0.size()), 64'd0);
        check("drain_q1", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
